w5300_tx_sched: RTL and testbench

Round-robin scheduler sharing the single TX path of `w5300_entry` between two independent requesters, each owning its own TX buffer, destination IP/port and payload size. It selects a requester and drives the `w5300_entry` request inputs: `dest_ip`, `dest_port`, `tx_data_size` and a one-cycle `tx_req`. It then tracks the `busy_n` handshake through to completion and returns a done or fail pulse to the winning requester. It sits between the application sources and `w5300_entry` in `top`, on the `wclk0` domain.

---
 rtl/w5300_tx_sched.sv | 209 ++++++++++++++++++++
 tb/tb_w5300_tx_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w5300_tx_sched.sv
// Round-robin scheduler that shares the single w5300_entry TX path between
// two requesters. It latches the winner's destination and size, issues a
// one-cycle tx_req, follows the busy_n handshake and returns a done or fail
// pulse to the winner. After each transfer it enforces a fixed idle gap.
module w5300_tx_sched #(
  parameter int CLK_FREQ   = 100,  // MHz
  parameter int TIMEOUT_MS = 10,
  parameter int ACK_CYCLES = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_0,
  input  logic        req_1,
  input  logic [31:0] ip_0,
  input  logic [31:0] ip_1,
  input  logic [15:0] port_0,
  input  logic [15:0] port_1,
  input  logic [31:0] size_0,
  input  logic [31:0] size_1,
  input  logic        busy_n,
  input  logic [2:0]  err_code,
  output logic        tx_req,
  output logic [31:0] dest_ip,
  output logic [15:0] dest_port,
  output logic [31:0] tx_data_size,
  output logic        buf_sel,
  output logic        grant_0,
  output logic        grant_1,
  output logic        done_0,
  output logic        done_1,
  output logic        fail_0,
  output logic        fail_1,
  output logic [2:0]  last_err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_WAIT_ACK  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_FINISH    = 3'd5;
  localparam logic [2:0] S_GAP       = 3'd6;

  // Terminal counter values; the counter is shared by WAIT_ACK, WAIT_DONE
  // and GAP since those phases never overlap.
  localparam logic [31:0] XFER_LAST = 32'(CLK_FREQ * 1000 * TIMEOUT_MS - 1);
  localparam logic [31:0] ACK_LAST  = 32'(ACK_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // Failure codes reported on last_err by the scheduler itself.
  localparam logic [2:0] ERR_ZERO_SIZE = 3'b111;
  localparam logic [2:0] ERR_ACK_TO    = 3'b110;
  localparam logic [2:0] ERR_XFER_TO   = 3'b101;

  logic [2:0]  state;
  logic [31:0] cnt;
  logic        last_served;  // requester granted most recently
  logic        sel;          // requester owning the current transfer
  logic        pick;
  logic [31:0] sel_size;
  logic        fin_go;
  logic        fin_fail;
  logic [2:0]  fin_code;

  // Arbitration choice and the decision to end the current transfer.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value held and infer a latch.
    pick     = req_1;
    sel_size = sel ? size_1 : size_0;
    fin_go   = 1'b0;
    fin_fail = 1'b0;
    fin_code = 3'b000;

    if (req_0 && req_1) begin
      pick = ~last_served;
    end

    case (state)
      S_LOAD: begin
        // A zero-byte payload never reaches w5300_entry.
        if (sel_size == '0) begin
          fin_go   = 1'b1;
          fin_fail = 1'b1;
          fin_code = ERR_ZERO_SIZE;
        end
      end
      S_WAIT_ACK: begin
        if (busy_n && (cnt >= ACK_LAST)) begin
          fin_go   = 1'b1;
          fin_fail = 1'b1;
          fin_code = ERR_ACK_TO;
        end
      end
      S_WAIT_DONE: begin
        // A busy_n rise on the timeout cycle still counts as completion.
        if (busy_n) begin
          fin_go   = 1'b1;
          fin_fail = (err_code != 3'b000);
          fin_code = err_code;
        end else if (cnt >= XFER_LAST) begin
          fin_go   = 1'b1;
          fin_fail = 1'b1;
          fin_code = ERR_XFER_TO;
        end
      end
      default: ;
    endcase
  end

  // Transfer sequencer: grant, load, request, handshake, result, gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      last_served  <= 1'b1;
      sel          <= 1'b0;
      tx_req       <= 1'b0;
      dest_ip      <= '0;
      dest_port    <= '0;
      tx_data_size <= '0;
      buf_sel      <= 1'b0;
      grant_0      <= 1'b0;
      grant_1      <= 1'b0;
      done_0       <= 1'b0;
      done_1       <= 1'b0;
      fail_0       <= 1'b0;
      fail_1       <= 1'b0;
      last_err     <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // below reads the values from before this clock edge.
      tx_req <= 1'b0;
      done_0 <= 1'b0;
      done_1 <= 1'b0;
      fail_0 <= 1'b0;
      fail_1 <= 1'b0;

      if (fin_go) begin
        state  <= S_FINISH;
        done_0 <= !fin_fail && !sel;
        done_1 <= !fin_fail && sel;
        fail_0 <= fin_fail && !sel;
        fail_1 <= fin_fail && sel;
        if (fin_fail) begin
          last_err <= fin_code;
        end
      end

      case (state)
        S_IDLE: begin
          if (req_0 || req_1) begin
            sel     <= pick;
            grant_0 <= !pick;
            grant_1 <= pick;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          dest_ip      <= sel ? ip_1 : ip_0;
          dest_port    <= sel ? port_1 : port_0;
          tx_data_size <= sel_size;
          buf_sel      <= sel;
          cnt          <= '0;
          if (!fin_go) begin
            tx_req <= 1'b1;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          // The REQ cycle itself counts towards the acknowledge budget.
          cnt   <= 32'd1;
          state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (!busy_n) begin
            cnt   <= '0;
            state <= S_WAIT_DONE;
          end else if (!fin_go) begin
            cnt <= cnt + 32'd1;
          end
        end
        S_WAIT_DONE: begin
          if (!fin_go) begin
            cnt <= cnt + 32'd1;
          end
        end
        S_FINISH: begin
          last_served <= sel;
          grant_0     <= 1'b0;
          grant_1     <= 1'b0;
          cnt         <= '0;
          state       <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
        S_GAP: begin
          if (cnt >= GAP_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_w5300_tx_sched.sv
// Self-checking bench for w5300_tx_sched. A transaction-level model plays
// both the requesters and w5300_entry; for each transfer it lays out the
// expected output timeline from the scheduler's latency rules, and a
// compare process checks every output against it on each falling edge.
module tb_w5300_tx_sched;

  localparam int CLK_FREQ   = 1;   // shrinks the transfer timeout to 1000 cycles
  localparam int TIMEOUT_MS = 1;
  localparam int ACK_CYCLES = 16;
  localparam int GAP_CYCLES = 4;
  localparam int TO         = CLK_FREQ * 1000 * TIMEOUT_MS;
  localparam int NEVER      = 99;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_0, req_1;
  logic [31:0] ip_0, ip_1;
  logic [15:0] port_0, port_1;
  logic [31:0] size_0, size_1;
  logic        busy_n;
  logic [2:0]  err_code;
  logic        tx_req;
  logic [31:0] dest_ip;
  logic [15:0] dest_port;
  logic [31:0] tx_data_size;
  logic        buf_sel;
  logic        grant_0, grant_1;
  logic        done_0, done_1;
  logic        fail_0, fail_1;
  logic [2:0]  last_err;

  w5300_tx_sched #(
    .CLK_FREQ  (CLK_FREQ),
    .TIMEOUT_MS(TIMEOUT_MS),
    .ACK_CYCLES(ACK_CYCLES),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_0       (req_0),
    .req_1       (req_1),
    .ip_0        (ip_0),
    .ip_1        (ip_1),
    .port_0      (port_0),
    .port_1      (port_1),
    .size_0      (size_0),
    .size_1      (size_1),
    .busy_n      (busy_n),
    .err_code    (err_code),
    .tx_req      (tx_req),
    .dest_ip     (dest_ip),
    .dest_port   (dest_port),
    .tx_data_size(tx_data_size),
    .buf_sel     (buf_sel),
    .grant_0     (grant_0),
    .grant_1     (grant_1),
    .done_0      (done_0),
    .done_1      (done_1),
    .fail_0      (fail_0),
    .fail_1      (fail_1),
    .last_err    (last_err)
  );

  always #5 clk = ~clk;

  // Expected outputs for the current cycle.
  logic        e_tx_req, e_buf_sel, e_grant_0, e_grant_1;
  logic        e_done_0, e_done_1, e_fail_0, e_fail_1;
  logic [31:0] e_dest_ip, e_size;
  logic [15:0] e_dest_port;
  logic [2:0]  e_last_err;
  int          last_served;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  // Observations of DUT behaviour, used by the hand-computed checks.
  int          last_txreq_cyc, last_fail_cyc, last_done_cyc;
  int          txreq_count = 0, pulse_count = 0;
  bit          seen_g1;
  int          obs_n_cyc, obs_rise_cyc;
  logic        obs_sel;
  logic [15:0] obs_port;
  logic [31:0] obs_size, obs_ip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: dut=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle; afterwards the DUT shows the new cycle's outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    e_tx_req = 1'b0;
    e_done_0 = 1'b0;
    e_done_1 = 1'b0;
    e_fail_0 = 1'b0;
    e_fail_1 = 1'b0;
  endtask

  task automatic clear_expect();
    e_tx_req = 1'b0; e_buf_sel = 1'b0; e_grant_0 = 1'b0; e_grant_1 = 1'b0;
    e_done_0 = 1'b0; e_done_1 = 1'b0; e_fail_0 = 1'b0; e_fail_1 = 1'b0;
    e_dest_ip = '0; e_size = '0; e_dest_port = '0; e_last_err = '0;
    last_served = 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_req"}, tx_req, 0);
    check({tag, "_grant_0"}, grant_0, 0);
    check({tag, "_grant_1"}, grant_1, 0);
    check({tag, "_buf_sel"}, buf_sel, 0);
    check({tag, "_dest_ip"}, dest_ip, 0);
    check({tag, "_dest_port"}, dest_port, 0);
    check({tag, "_size"}, tx_data_size, 0);
    check({tag, "_pulses"}, {done_0, done_1, fail_0, fail_1}, 0);
    check({tag, "_last_err"}, last_err, 0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    clear_expect();
    busy_n = 1'b1; err_code = '0; req_0 = 1'b0; req_1 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One complete transfer, entered and left with the scheduler idle.
  // ack_delay: cycles after tx_req until busy_n falls (>= ACK_CYCLES: never)
  // low_len:   cycles busy_n stays low;  err: err_code presented at the rise
  // rst_after: WAIT_DONE cycle at which reset is pulsed (0: none)
  task automatic xfer(input logic [1:0] mask, input int ack_delay, input int low_len,
                      input logic [2:0] err, input int rst_after, input bit hold,
                      input bit drop);
    int          w;
    logic [31:0] cip, csz;
    logic [15:0] cpt;
    bit          fail, acked;
    logic [2:0]  code;
    obs_n_cyc = cyc;
    req_0 = mask[0];
    req_1 = mask[1];
    if (mask == 2'b11) w = 1 - last_served;
    else w = mask[1] ? 1 : 0;
    tick();  // grant cycle
    if (w == 1) e_grant_1 = 1'b1; else e_grant_0 = 1'b1;
    cip = (w == 1) ? ip_1 : ip_0;
    cpt = (w == 1) ? port_1 : port_0;
    csz = (w == 1) ? size_1 : size_0;
    tick();  // request cycle
    e_dest_ip = cip; e_dest_port = cpt; e_size = csz; e_buf_sel = (w == 1);
    obs_sel = buf_sel; obs_port = dest_port; obs_size = tx_data_size; obs_ip = dest_ip;
    // Later changes to the requester inputs must be ignored.
    ip_0 = $urandom; ip_1 = $urandom; port_0 = 16'($urandom); port_1 = 16'($urandom);
    size_0 = $urandom; size_1 = $urandom;
    if (drop) begin
      if (w == 1) req_1 = 1'b0; else req_0 = 1'b0;
    end
    fail = 1'b0;
    code = 3'b000;
    if (csz == 0) begin
      fail = 1'b1;
      code = 3'b111;
    end else begin
      e_tx_req = 1'b1;
      acked = 1'b0;
      for (int k = 1; k < ACK_CYCLES; k++) begin
        tick();
        err_code = 3'($urandom);
        if (k == ack_delay) begin
          busy_n = 1'b0;
          acked = 1'b1;
          break;
        end
      end
      if (!acked) begin
        tick();
        fail = 1'b1;
        code = 3'b110;
      end else if (low_len <= TO) begin
        for (int j = 1; j < low_len; j++) begin
          tick();
          err_code = 3'($urandom);
          if (j == rst_after) begin
            do_reset();
            return;
          end
        end
        tick();
        busy_n = 1'b1;
        err_code = err;
        obs_rise_cyc = cyc;
        tick();
        err_code = 3'($urandom);
        fail = (err != 3'b000);
        code = err;
      end else begin
        for (int j = 1; j <= TO; j++) begin
          tick();
          err_code = 3'($urandom);
        end
        tick();
        busy_n = 1'b1;
        fail = 1'b1;
        code = 3'b101;
      end
    end
    // Result cycle: pulse to the winner, grant still held.
    if (fail) begin
      if (w == 1) e_fail_1 = 1'b1; else e_fail_0 = 1'b1;
      e_last_err = code;
    end else begin
      if (w == 1) e_done_1 = 1'b1; else e_done_0 = 1'b1;
    end
    last_served = w;
    if (!hold) begin
      req_0 = 1'b0;
      req_1 = 1'b0;
    end
    tick();
    e_grant_0 = 1'b0;
    e_grant_1 = 1'b0;
    err_code = '0;
    repeat (GAP_CYCLES) tick();
  endtask

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("tx_req", tx_req, e_tx_req);
      check("grant_0", grant_0, e_grant_0);
      check("grant_1", grant_1, e_grant_1);
      check("buf_sel", buf_sel, e_buf_sel);
      check("dest_ip", dest_ip, e_dest_ip);
      check("dest_port", dest_port, e_dest_port);
      check("tx_data_size", tx_data_size, e_size);
      check("done_0", done_0, e_done_0);
      check("done_1", done_1, e_done_1);
      check("fail_0", fail_0, e_fail_0);
      check("fail_1", fail_1, e_fail_1);
      check("last_err", last_err, e_last_err);
      if (tx_req) begin
        last_txreq_cyc = cyc;
        txreq_count++;
      end
      if (fail_0 || fail_1) last_fail_cyc = cyc;
      if (done_0 || done_1) last_done_cyc = cyc;
      if (done_0 || done_1 || fail_0 || fail_1) pulse_count++;
      if (grant_1) seen_g1 = 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int np, nt;
    rst_n = 1'b0;
    req_0 = 1'b0; req_1 = 1'b0;
    ip_0 = '0; ip_1 = '0; port_0 = '0; port_1 = '0; size_0 = '0; size_1 = '0;
    busy_n = 1'b1; err_code = '0;
    clear_expect();
    tick();
    cmp_en = 1'b1;
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    tick();

    // Single request from requester 0.
    ip_0 = 32'hC0A8_6F01; port_0 = 16'd7000; size_0 = 32'd400;
    seen_g1 = 1'b0;
    xfer(2'b01, 3, 50, 3'b000, 0, 1'b0, 1'b0);
    check("t1_port", obs_port, 16'd7000);
    check("t1_size", obs_size, 32'd400);
    check("t1_ip", obs_ip, 32'hC0A8_6F01);
    check("t1_txreq_latency", last_txreq_cyc - obs_n_cyc, 2);
    check("t1_done_latency", last_done_cyc - obs_rise_cyc, 1);
    check("t1_grant_1_seen", seen_g1, 0);

    // Requester 1 alone, then four back-to-back ties.
    ip_1 = 32'h0A00_0002; port_1 = 16'd80; size_1 = 32'd64;
    xfer(2'b10, 5, 10, 3'b000, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ip_0 = $urandom; ip_1 = $urandom; port_0 = 16'($urandom); port_1 = 16'($urandom);
      size_0 = 32'($urandom_range(1, 1500)); size_1 = 32'($urandom_range(1, 1500));
      xfer(2'b11, $urandom_range(1, 15), $urandom_range(1, 20), 3'b000, 0, i < 3, 1'b0);
      check($sformatf("tie_sel_%0d", i), obs_sel, i % 2);
    end

    // err_code reported at the busy_n rise, then a success keeps last_err.
    size_0 = 32'd100;
    xfer(2'b01, 2, 20, 3'b010, 0, 1'b0, 1'b0);
    check("err_fail_latency", last_fail_cyc - obs_rise_cyc, 1);
    check("err_last_err", last_err, 3'b010);
    size_1 = 32'd200;
    xfer(2'b10, 2, 10, 3'b000, 0, 1'b0, 1'b1);
    check("err_sticky", last_err, 3'b010);

    // busy_n never falls; the other requester must be served next.
    size_0 = 32'd300; size_1 = 32'd300;
    xfer(2'b11, NEVER, 1, 3'b000, 0, 1'b0, 1'b0);
    check("ack_to_sel", obs_sel, 0);
    check("ack_to_latency", last_fail_cyc - last_txreq_cyc, ACK_CYCLES);
    check("ack_to_last_err", last_err, 3'b110);
    size_0 = 32'd300; size_1 = 32'd300;
    xfer(2'b11, 4, 10, 3'b000, 0, 1'b0, 1'b0);
    check("ack_to_next_sel", obs_sel, 1);

    // Zero size: no tx_req, fail two cycles after the request.
    size_1 = 32'd0;
    nt = txreq_count;
    xfer(2'b10, 3, 10, 3'b000, 0, 1'b0, 1'b0);
    check("zero_fail_latency", last_fail_cyc - obs_n_cyc, 2);
    check("zero_last_err", last_err, 3'b111);
    check("zero_no_txreq", txreq_count - nt, 0);

    // Reset during WAIT_DONE after requester 0 was served last.
    size_0 = 32'd500;
    xfer(2'b01, 2, 5, 3'b000, 0, 1'b0, 1'b0);
    size_0 = 32'd500;
    np = pulse_count;
    xfer(2'b01, 3, 40, 3'b000, 10, 1'b0, 1'b0);
    check("rst_no_pulse", pulse_count - np, 0);
    size_0 = 32'd10; size_1 = 32'd10;
    xfer(2'b11, 2, 3, 3'b000, 0, 1'b0, 1'b0);
    check("rst_tie_sel", obs_sel, 0);

    // Transfer timeout and its exact boundary.
    size_0 = 32'd1000;
    xfer(2'b01, 2, TO + 3, 3'b000, 0, 1'b0, 1'b0);
    check("xfer_to_last_err", last_err, 3'b101);
    size_0 = 32'd1000;
    np = pulse_count;
    xfer(2'b01, 2, TO, 3'b000, 0, 1'b0, 1'b0);
    check("xfer_edge_done", last_done_cyc - obs_rise_cyc, 1);
    check("xfer_edge_last_err", last_err, 3'b101);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      logic [1:0] mask;
      logic [2:0] err;
      int         ad;
      bit         hold;
      mask = 2'($urandom_range(1, 3));
      ip_0 = $urandom; ip_1 = $urandom; port_0 = 16'($urandom); port_1 = 16'($urandom);
      size_0 = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 2000));
      size_1 = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 2000));
      ad = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, 15);
      err = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      hold = 1'($urandom_range(0, 1));
      xfer(mask, ad, $urandom_range(1, 40), err, 0, hold, 1'($urandom_range(0, 1)));
      if (!hold) repeat ($urandom_range(0, 3)) tick();
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
